// File: rtl/pll_reset_sequencer.sv
// PLL power-up/recovery sequencer: POR hold, lock qualification, run supervision, bounded retry.
// Optional soft restart from RUN when PLL_SEQ_SOFT_RESET_EN is defined.
module pll_reset_sequencer #(
  parameter int unsigned POR_CYCLES          = 128,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
  parameter int unsigned STABLE_CYCLES       = 1024,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       EXT_CLK_50MHz,
  input  logic       BTN_RESET_n,
  input  logic       pll_locked_i,
`ifdef PLL_SEQ_SOFT_RESET_EN
  input  logic       soft_reset_req_i,
`endif
  output logic       pll_areset_o,
  output logic       soc_reset_n_o,
  output logic [2:0] seq_state_o,
  output logic [3:0] retry_cnt_o,
  output logic       lock_lost_o,
  output logic       lock_fail_o
);

  localparam int unsigned PorW  = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam int unsigned TmoW  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
  localparam int unsigned StabW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;

  localparam logic [PorW-1:0]  PorLast   = PorW'(POR_CYCLES - 1);
  localparam logic [TmoW-1:0]  TmoLast   = TmoW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [StabW-1:0] StabLast  = StabW'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RetryLast = 4'(MAX_RETRIES - 1);
  localparam logic [3:0]       RetryMax  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StPor      = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [PorW-1:0]   por_cnt_q, por_cnt_d;
  logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d, tmo_inc;
  logic [StabW-1:0]  stab_cnt_q, stab_cnt_d;
  logic [3:0]        retry_cnt_q, retry_cnt_d;
  logic              lock_lost_q, lock_lost_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              locked_s;
  logic              retry;
  logic              soft_rise;
  logic              pll_areset_q, soc_reset_n_q, lock_fail_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

`ifdef PLL_SEQ_SOFT_RESET_EN
  logic soft_req_q;
  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) soft_req_q <= 1'b0;
    else              soft_req_q <= soft_reset_req_i;
  end
  assign soft_rise = soft_reset_req_i & ~soft_req_q;
`else
  assign soft_rise = 1'b0;
`endif

  // Saturating so a lock seen on the last timeout cycle cannot wrap the budget.
  assign tmo_inc = (tmo_cnt_q == TmoLast) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);

  always_comb begin
    state_d     = state_q;
    por_cnt_d   = '0;
    tmo_cnt_d   = '0;
    stab_cnt_d  = '0;
    retry_cnt_d = retry_cnt_q;
    lock_lost_d = lock_lost_q;
    retry       = 1'b0;
    unique case (state_q)
      StPor: begin
        if (por_cnt_q == PorLast) state_d = StWaitLock;
        else                      por_cnt_d = por_cnt_q + PorW'(1);
      end
      StWaitLock: begin
        if (locked_s) begin
          state_d   = StStable;
          tmo_cnt_d = tmo_inc;
        end else if (tmo_cnt_q == TmoLast) begin
          retry = 1'b1;
        end else begin
          tmo_cnt_d = tmo_inc;
        end
      end
      StStable: begin
        if (locked_s && stab_cnt_q == StabLast) begin
          state_d = StRun;
        end else if (tmo_cnt_q == TmoLast) begin
          retry = 1'b1;
        end else if (!locked_s) begin
          state_d   = StWaitLock;
          tmo_cnt_d = tmo_inc;
        end else begin
          stab_cnt_d = stab_cnt_q + StabW'(1);
          tmo_cnt_d  = tmo_inc;
        end
      end
      StRun: begin
        if (!locked_s) begin
          state_d     = StPor;
          lock_lost_d = 1'b1;
        end else if (soft_rise) begin
          state_d = StPor;
        end
      end
      StFail: ;
      default: state_d = StPor;
    endcase

    if (retry) begin
      if (retry_cnt_q == RetryLast) begin
        state_d     = StFail;
        retry_cnt_d = RetryMax;
      end else begin
        state_d     = StPor;
        retry_cnt_d = retry_cnt_q + 4'd1;
      end
    end
    if (state_d == StRun) retry_cnt_d = '0;
  end

  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) begin
      state_q       <= StPor;
      por_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      stab_cnt_q    <= '0;
      retry_cnt_q   <= '0;
      lock_lost_q   <= 1'b0;
      sync_q        <= '0;
      pll_areset_q  <= 1'b1;
      soc_reset_n_q <= 1'b0;
      lock_fail_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      por_cnt_q     <= por_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      stab_cnt_q    <= stab_cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      lock_lost_q   <= lock_lost_d;
      sync_q        <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
      pll_areset_q  <= (state_d == StPor) || (state_d == StFail);
      soc_reset_n_q <= (state_d == StRun);
      lock_fail_q   <= (state_d == StFail);
    end
  end

  assign pll_areset_o  = pll_areset_q;
  assign soc_reset_n_o = soc_reset_n_q;
  assign seq_state_o   = state_q;
  assign retry_cnt_o   = retry_cnt_q;
  assign lock_lost_o   = lock_lost_q;
  assign lock_fail_o   = lock_fail_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters.
// Soft-restart steps are included when PLL_SEQ_SOFT_RESET_EN is defined.
module tb_pll_reset_sequencer;

  localparam int unsigned POR_CYCLES          = 8;
  localparam int unsigned LOCK_TIMEOUT_CYCLES = 64;
  localparam int unsigned STABLE_CYCLES       = 16;
  localparam int unsigned MAX_RETRIES         = 2;
  localparam int unsigned SYNC_STAGES         = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
`ifdef PLL_SEQ_SOFT_RESET_EN
  logic       soft_req = 1'b0;
`endif
  logic       pll_areset, soc_reset_n, lock_lost, lock_fail;
  logic [2:0] seq_state;
  logic [3:0] retry_cnt;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #10 clk = ~clk;

  pll_reset_sequencer #(
    .POR_CYCLES          (POR_CYCLES),
    .LOCK_TIMEOUT_CYCLES (LOCK_TIMEOUT_CYCLES),
    .STABLE_CYCLES       (STABLE_CYCLES),
    .MAX_RETRIES         (MAX_RETRIES),
    .SYNC_STAGES         (SYNC_STAGES)
  ) dut (
    .EXT_CLK_50MHz    (clk),
    .BTN_RESET_n      (rst_n),
    .pll_locked_i     (lock),
`ifdef PLL_SEQ_SOFT_RESET_EN
    .soft_reset_req_i (soft_req),
`endif
    .pll_areset_o     (pll_areset),
    .soc_reset_n_o    (soc_reset_n),
    .seq_state_o      (seq_state),
    .retry_cnt_o      (retry_cnt),
    .lock_lost_o      (lock_lost),
    .lock_fail_o      (lock_fail)
  );

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic ar,
                           input logic sr, input logic [3:0] rc, input logic ll,
                           input logic lf);
    check({tag, ".state"}, {5'd0, seq_state}, {5'd0, st});
    check({tag, ".areset"}, {7'd0, pll_areset}, {7'd0, ar});
    check({tag, ".soc_rst_n"}, {7'd0, soc_reset_n}, {7'd0, sr});
    check({tag, ".retry"}, {4'd0, retry_cnt}, {4'd0, rc});
    check({tag, ".lost"}, {7'd0, lock_lost}, {7'd0, ll});
    check({tag, ".fail"}, {7'd0, lock_fail}, {7'd0, lf});
  endtask

  // Release lands just after an edge, so the next edge is cycle 1.
  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    tick(2);
    check_all("reset", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Nominal bring-up
    tick(7);
    check_all("nom.c7", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    check_all("nom.c8", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(4);
    lock = 1'b1;
    tick(2);
    check("nom.sync_wait", {5'd0, seq_state}, 8'd1);
    tick(1);
    check("nom.stable", {5'd0, seq_state}, 8'd2);
    tick(15);
    check("nom.pre_run_rst", {7'd0, soc_reset_n}, 8'd0);
    tick(1);
    check_all("nom.run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Lock loss in RUN
    lock = 1'b0;
    tick(2);
    check("loss.still_run", {7'd0, soc_reset_n}, 8'd1);
    tick(1);
    check_all("loss.por", 3'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    lock = 1'b1;
    tick(8);
    check("loss.wait", {5'd0, seq_state}, 8'd1);
    tick(1);
    check("loss.stable", {5'd0, seq_state}, 8'd2);
    tick(15);
    check("loss.pre_run", {5'd0, seq_state}, 8'd2);
    tick(1);
    check_all("loss.rerun", 3'd3, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

    // Glitchy lock
    lock = 1'b0;
    pulse_reset();
    tick(8);
    check("glitch.wait", {5'd0, seq_state}, 8'd1);
    lock = 1'b1;
    tick(10);
    check("glitch.stable", {5'd0, seq_state}, 8'd2);
    lock = 1'b0;
    tick(3);
    check("glitch.back", {5'd0, seq_state}, 8'd1);
    lock = 1'b1;
    tick(2);
    check("glitch.resync", {5'd0, seq_state}, 8'd1);
    tick(1);
    check("glitch.stable2", {5'd0, seq_state}, 8'd2);
    tick(15);
    check("glitch.pre_run", {5'd0, seq_state}, 8'd2);
    tick(1);
    check_all("glitch.run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Reset mid-operation at stab_cnt=7
    lock = 1'b0;
    pulse_reset();
    tick(8);
    lock = 1'b1;
    tick(10);
    check("mid.stable", {5'd0, seq_state}, 8'd2);
    rst_n = 1'b0;
    #1;
    check_all("mid.async", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;
    tick(8);
    check("mid.wait", {5'd0, seq_state}, 8'd1);
    tick(1);
    check("mid.stable2", {5'd0, seq_state}, 8'd2);
    tick(16);
    check_all("mid.run", 3'd3, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0);

    // Lock never asserts
    lock = 1'b0;
    pulse_reset();
    tick(71);
    check("nolock.wait", {5'd0, seq_state}, 8'd1);
    tick(1);
    check_all("nolock.retry1", 3'd0, 1'b1, 1'b0, 4'd1, 1'b0, 1'b0);
    tick(71);
    check("nolock.wait2", {5'd0, seq_state}, 8'd1);
    tick(1);
    check_all("nolock.fail", 3'd4, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    lock = 1'b1;
    tick(30);
    check_all("nolock.parked", 3'd4, 1'b1, 1'b0, 4'd2, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all("nolock.btn", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    tick(1);
    rst_n = 1'b1;

`ifdef PLL_SEQ_SOFT_RESET_EN
    // Soft restart
    tick(25);
    check("soft.run", {5'd0, seq_state}, 8'd3);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    check_all("soft.por", 3'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    lock = 1'b0;
    tick(8);
    check("soft.wait", {5'd0, seq_state}, 8'd1);
    soft_req = 1'b1;
    tick(1);
    soft_req = 1'b0;
    check("soft.ignored", {5'd0, seq_state}, 8'd1);
    tick(1);
    check_all("soft.ignored2", 3'd1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
